// File: rtl/com_bus_rr_arbiter.sv
// Common-bus arbiter: round-robin processor ownership with a nested snoop/memory
// data-phase sub-arbiter, one-cycle turnaround and a sticky hold-timeout flag.
module com_bus_rr_arbiter #(
  parameter int unsigned NUM_PROC  = 8,
  parameter int unsigned NUM_SNOOP = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PROC-1:0]         Com_Bus_Req_proc,
  input  logic [NUM_SNOOP-1:0]        Com_Bus_Req_snoop,
  input  logic                        Mem_snoop_req,
  output logic [NUM_PROC-1:0]         Com_Bus_Gnt_proc,
  output logic [NUM_SNOOP-1:0]        Com_Bus_Gnt_snoop,
  output logic                        Mem_snoop_gnt,
  output logic                        Bus_busy,
  output logic [$clog2(NUM_PROC)-1:0] Cur_owner,
  output logic                        Bus_timeout
);

  localparam int unsigned PW = $clog2(NUM_PROC);
  localparam int unsigned SW = $clog2(NUM_SNOOP);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [SW-1:0] snp_ptr;
  logic [CW-1:0] hold_cnt;

  logic          proc_found;
  logic [PW-1:0] proc_idx;
  logic          snp_found;
  logic [SW-1:0] snp_idx;
  logic          owner_req;
  logic          snp_busy;
  logic [CW-1:0] cnt_inc;
  int unsigned   pk;
  int unsigned   sk;

  // Round-robin searches starting at each pointer, ascending with wrap
  always_comb begin
    proc_found = 1'b0;
    proc_idx   = '0;
    snp_found  = 1'b0;
    snp_idx    = '0;
    pk         = 0;
    sk         = 0;
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      pk = (32'(rr_ptr) + i) % NUM_PROC;
      if (!proc_found && Com_Bus_Req_proc[PW'(pk)]) begin
        proc_found = 1'b1;
        proc_idx   = PW'(pk);
      end
    end
    for (int unsigned i = 0; i < NUM_SNOOP; i++) begin
      sk = (32'(snp_ptr) + i) % NUM_SNOOP;
      if (!snp_found && Com_Bus_Req_snoop[SW'(sk)]) begin
        snp_found = 1'b1;
        snp_idx   = SW'(sk);
      end
    end
  end

  assign owner_req = Com_Bus_Req_proc[Cur_owner];
  assign snp_busy  = (|Com_Bus_Gnt_snoop) | Mem_snoop_gnt;
  assign cnt_inc   = (hold_cnt == {CW{1'b1}}) ? hold_cnt : hold_cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      snp_ptr           <= '0;
      hold_cnt          <= '0;
      Com_Bus_Gnt_proc  <= '0;
      Com_Bus_Gnt_snoop <= '0;
      Mem_snoop_gnt     <= 1'b0;
      Bus_busy          <= 1'b0;
      Cur_owner         <= '0;
      Bus_timeout       <= 1'b0;
    end else begin
      case (state)
        // RELEASE is the one-cycle turnaround; a pending request wins at its end
        IDLE, RELEASE: begin
          state <= IDLE;
          if (proc_found) begin
            state            <= OWN;
            Com_Bus_Gnt_proc <= NUM_PROC'(1) << proc_idx;
            Bus_busy         <= 1'b1;
            Cur_owner        <= proc_idx;
            rr_ptr           <= PW'((32'(proc_idx) + 32'd1) % NUM_PROC);
            hold_cnt         <= '0;
          end
        end
        OWN: begin
          hold_cnt <= cnt_inc;
          if (32'(cnt_inc) >= TIMEOUT) Bus_timeout <= 1'b1;
          if (!owner_req && !snp_busy) begin
            state            <= RELEASE;
            Com_Bus_Gnt_proc <= '0;
            Bus_busy         <= 1'b0;
            Cur_owner        <= '0;
          end else if (snp_busy) begin
            // Active data-phase grant is held until its request drops
            if ((|Com_Bus_Gnt_snoop) && !(|(Com_Bus_Gnt_snoop & Com_Bus_Req_snoop)))
              Com_Bus_Gnt_snoop <= '0;
            if (Mem_snoop_gnt && !Mem_snoop_req)
              Mem_snoop_gnt <= 1'b0;
          end else if (snp_found) begin
            Com_Bus_Gnt_snoop <= NUM_SNOOP'(1) << snp_idx;
            snp_ptr           <= SW'((32'(snp_idx) + 32'd1) % NUM_SNOOP);
          end else if (Mem_snoop_req) begin
            Mem_snoop_gnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_com_bus_rr_arbiter.sv
// Directed bench for com_bus_rr_arbiter (TIMEOUT overridden to 10); each task
// drives one scenario and compares the full output vector against hand values.
module tb_com_bus_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_p = '0;
  logic [3:0] req_s = '0;
  logic       mreq = 1'b0;
  logic [7:0] gnt_p;
  logic [3:0] gnt_s;
  logic       mgnt;
  logic       busy;
  logic [2:0] owner;
  logic       tmo;

  int checks = 0;
  int fails  = 0;

  com_bus_rr_arbiter #(.NUM_PROC(8), .NUM_SNOOP(4), .TIMEOUT(10)) dut (
    .clk               (clk),
    .rst               (rst),
    .Com_Bus_Req_proc  (req_p),
    .Com_Bus_Req_snoop (req_s),
    .Mem_snoop_req     (mreq),
    .Com_Bus_Gnt_proc  (gnt_p),
    .Com_Bus_Gnt_snoop (gnt_s),
    .Mem_snoop_gnt     (mgnt),
    .Bus_busy          (busy),
    .Cur_owner         (owner),
    .Bus_timeout       (tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {gnt_p, gnt_s, mgnt, busy, owner, tmo};
  endfunction

  // Expected vector; Bus_busy is the OR of the processor grant
  function automatic logic [17:0] mk(input logic [7:0] p, input logic [3:0] s,
                                     input logic m, input logic [2:0] o, input logic t);
    return {p, s, m, |p, o, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_p = '0; req_s = '0; mreq = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    #1;
    e = mk(8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL reset_held: got %h want %h", outs(), e); end
    req_p = 8'hFF;
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL reset_ignores_req: got %h want %h", outs(), e); end
    req_p = '0;
    rst = 1'b0;
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL reset_idle: got %h want %h", outs(), e); end
  endtask

  task automatic test_single();
    logic [17:0] e;
    do_reset();
    req_p = 8'h01;
    #1;
    e = mk(8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL single_latency: got %h want %h", outs(), e); end
    tick();
    e = mk(8'h01, 4'h0, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL single_grant: got %h want %h", outs(), e); end
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL single_hold: got %h want %h", outs(), e); end
    req_p = 8'h00;
    tick();
    e = mk(8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL single_release: got %h want %h", outs(), e); end
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL single_idle: got %h want %h", outs(), e); end
  endtask

  task automatic test_round_robin();
    logic [17:0] e;
    logic [2:0]  o;
    do_reset();
    req_p = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      o = 3'(n % 8);
      e = mk(8'h01 << o, 4'h0, 1'b0, o, 1'b0);
      checks++; if (outs() !== e) begin fails++; $display("FAIL rr_grant[%0d]: got %h want %h", n, outs(), e); end
      tick();
      tick();
      checks++; if (outs() !== e) begin fails++; $display("FAIL rr_hold[%0d]: got %h want %h", n, outs(), e); end
      req_p[o] = 1'b0;
      tick();
      e = mk(8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
      checks++; if (outs() !== e) begin fails++; $display("FAIL rr_turnaround[%0d]: got %h want %h", n, outs(), e); end
      req_p = (n < 8) ? 8'hFF : 8'h00;
      tick();
    end
  endtask

  task automatic test_snoop();
    logic [17:0] e;
    do_reset();
    req_p = 8'h04;
    tick();
    req_s = 4'b1010; mreq = 1'b1;
    tick();
    e = mk(8'h04, 4'b0010, 1'b0, 3'd2, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_first: got %h want %h", outs(), e); end
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_hold: got %h want %h", outs(), e); end
    req_s = 4'b1000;
    tick();
    e = mk(8'h04, 4'b0000, 1'b0, 3'd2, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_gap1: got %h want %h", outs(), e); end
    tick();
    e = mk(8'h04, 4'b1000, 1'b0, 3'd2, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_second: got %h want %h", outs(), e); end
    req_s = 4'b0000;
    tick();
    e = mk(8'h04, 4'b0000, 1'b0, 3'd2, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_gap2: got %h want %h", outs(), e); end
    tick();
    e = mk(8'h04, 4'b0000, 1'b1, 3'd2, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_mem: got %h want %h", outs(), e); end
    mreq = 1'b0;
    tick();
    e = mk(8'h04, 4'b0000, 1'b0, 3'd2, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_mem_drop: got %h want %h", outs(), e); end
    // Owner leaving takes the turnaround; snoop requests outside OWN are ignored
    req_p = 8'h00; req_s = 4'b0001; mreq = 1'b1;
    tick();
    e = mk(8'h00, 4'b0000, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_release: got %h want %h", outs(), e); end
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL snoop_idle_ignored: got %h want %h", outs(), e); end
    req_s = '0; mreq = 1'b0;
  endtask

  task automatic test_retain();
    logic [17:0] e;
    do_reset();
    req_p = 8'h20;
    tick();
    req_s = 4'b0100;
    tick();
    e = mk(8'h20, 4'b0100, 1'b0, 3'd5, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL retain_snoop: got %h want %h", outs(), e); end
    req_p = 8'h00;
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL retain_owner_low: got %h want %h", outs(), e); end
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL retain_owner_low2: got %h want %h", outs(), e); end
    req_s = 4'b0000;
    tick();
    e = mk(8'h20, 4'b0000, 1'b0, 3'd5, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL retain_snoop_drop: got %h want %h", outs(), e); end
    tick();
    e = mk(8'h00, 4'b0000, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL retain_release: got %h want %h", outs(), e); end
  endtask

  task automatic test_timeout();
    logic [17:0] e;
    do_reset();
    req_p = 8'h01;
    tick();
    for (int k = 1; k < 10; k++) tick();
    e = mk(8'h01, 4'h0, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL timeout_before: got %h want %h", outs(), e); end
    tick();
    e = mk(8'h01, 4'h0, 1'b0, 3'd0, 1'b1);
    checks++; if (outs() !== e) begin fails++; $display("FAIL timeout_set: got %h want %h", outs(), e); end
    for (int k = 11; k < 20; k++) tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL timeout_grant_kept: got %h want %h", outs(), e); end
    req_p = 8'h00;
    tick();
    e = mk(8'h00, 4'h0, 1'b0, 3'd0, 1'b1);
    checks++; if (outs() !== e) begin fails++; $display("FAIL timeout_sticky_release: got %h want %h", outs(), e); end
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL timeout_sticky_idle: got %h want %h", outs(), e); end
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
    do_reset();
    e = mk(8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL rm_flag_cleared: got %h want %h", outs(), e); end
    req_p = 8'h08;
    tick();
    mreq = 1'b1;
    tick();
    e = mk(8'h08, 4'h0, 1'b1, 3'd3, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL rm_mem_active: got %h want %h", outs(), e); end
    #2 rst = 1'b1;
    #1;
    e = mk(8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL rm_async_clear: got %h want %h", outs(), e); end
    tick();
    checks++; if (outs() !== e) begin fails++; $display("FAIL rm_held: got %h want %h", outs(), e); end
    rst = 1'b0; mreq = 1'b0;
    #1;
    checks++; if (outs() !== e) begin fails++; $display("FAIL rm_no_early_grant: got %h want %h", outs(), e); end
    tick();
    e = mk(8'h08, 4'h0, 1'b0, 3'd3, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL rm_regrant: got %h want %h", outs(), e); end
    // Pointer is now 4; after a reset pulse procs 0 and 7 must resolve to 0
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    req_p = 8'h81;
    tick();
    e = mk(8'h01, 4'h0, 1'b0, 3'd0, 1'b0);
    checks++; if (outs() !== e) begin fails++; $display("FAIL rm_ptr_restart: got %h want %h", outs(), e); end
    req_p = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_snoop();
    test_retain();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/com_bus_rr_arbiter.md
COM_BUS_RR_ARBITER -- requirements
Module: com_bus_rr_arbiter

Interface
REQ-001 Parameter NUM_PROC, 8, number of processor-side requesters (index width 3).
REQ-002 Parameter NUM_SNOOP, 4, number of cache snoop-side requesters.
REQ-003 Parameter TIMEOUT, 255, maximum cycles a processor grant is held before the timeout flag is raised.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 Com_Bus_Req_proc  input  NUM_PROC  per-processor common-bus request, level, held until the transaction completes.
REQ-007 Com_Bus_Req_snoop  input  NUM_SNOOP  per-cache snoop data-phase request, level.
REQ-008 Mem_snoop_req  input  1  memory request to supply or accept data on the bus.
REQ-009 Com_Bus_Gnt_proc  output  NUM_PROC  processor grant, one-hot or zero, registered.
REQ-010 Com_Bus_Gnt_snoop  output  NUM_SNOOP  snoop grant, one-hot or zero, registered.
REQ-011 Mem_snoop_gnt  output  1  memory grant, registered.
REQ-012 Bus_busy  output  1  high while any processor grant is active.
REQ-013 Cur_owner  output  3  index of the granted processor; 0 when idle.
REQ-014 Bus_timeout  output  1  sticky flag: a processor grant exceeded TIMEOUT cycles.

Function
REQ-015 Processor FSM states: IDLE, OWN, RELEASE; reset state IDLE.
REQ-016 IDLE: any Com_Bus_Req_proc bit set at an edge -> OWN; winner's grant bit asserts from that edge, i.e. request-to-grant latency 1 cycle.
REQ-017 Winner selection: round-robin; search starts at pointer rr_ptr and ascends with wrap from NUM_PROC-1 to 0; first set bit wins.
REQ-018 On each processor grant to index i, rr_ptr <= (i+1) mod NUM_PROC; rr_ptr resets to 0.
REQ-019 OWN: grant held while the owner's request stays high; non-owner requests are ignored and never preempt.
REQ-020 OWN: owner request low at an edge with no snoop or memory grant active -> RELEASE; processor grant deasserts at that edge.
REQ-021 OWN: owner request low while a snoop or memory grant is active -> stay in OWN with grant held until that grant clears, then -> RELEASE.
REQ-022 RELEASE lasts exactly 1 cycle with all grants low (bus turnaround), then -> IDLE; requests pending in RELEASE are granted on the following edge.
REQ-023 Snoop sub-arbiter evaluates only in OWN; in IDLE and RELEASE, snoop and memory requests are ignored and their grants stay 0.
REQ-024 Snoop priority: any Com_Bus_Req_snoop bit beats Mem_snoop_req; snoops are round-robin with separate pointer snp_ptr (reset 0, advances to granted index +1 mod NUM_SNOOP).
REQ-025 At most one of Com_Bus_Gnt_snoop and Mem_snoop_gnt is high at any time; snoop/memory grant latency is 1 cycle from request.
REQ-026 A snoop or memory grant is held until its request drops, then deasserts at that edge; no new snoop/memory grant is issued in the same cycle (1 idle cycle between consecutive snoop-phase grants).
REQ-027 Bus_busy equals OR of Com_Bus_Gnt_proc; Cur_owner is the owner index in OWN, else 0.
REQ-028 Hold counter: 8 bits, clears on entry to OWN, increments each OWN cycle, saturates at 255; when it reaches TIMEOUT, Bus_timeout sets and stays set until reset. The grant is not revoked.
REQ-029 Simultaneous requests on all NUM_PROC inputs with rr_ptr=k -> index k granted.
REQ-030 Invariant: Com_Bus_Gnt_proc is never multi-hot; a grant bit is never high while its request was low at the preceding edge, except as retained under REQ-021.

Reset
REQ-031 rst high forces, immediately and independently of clk: state IDLE, all grants 0, Bus_busy 0, Cur_owner 0, Bus_timeout 0, rr_ptr 0, snp_ptr 0, hold counter 0.
REQ-032 Reset asserted mid-transaction drops all grants at once; after deassertion the first grant issues no earlier than the first rising edge at which rst is low.

Verification
REQ-033 Req_proc=8'b0000_0001 from reset -> Gnt_proc=8'b0000_0001 after 1 edge, Bus_busy=1, Cur_owner=0; drop req -> grant 0, then 1 idle cycle.
REQ-034 Req_proc=8'hFF held, each owner drops its req after 3 cycles -> grant order 0,1,...,7,0, with 1 RELEASE cycle between owners.
REQ-035 Proc 2 owns; Req_snoop=4'b1010 and Mem_snoop_req=1 together -> Gnt_snoop=4'b0010, then after release + 1 idle cycle 4'b1000, then Mem_snoop_gnt=1; never two grants together.
REQ-036 Proc 5 drops its req while Gnt_snoop=4'b0100 -> Gnt_proc bit 5 stays high until snoop req drops, then RELEASE.
REQ-037 TIMEOUT=10, owner holds req for 20 cycles -> Bus_timeout=1 at cycle 10 of OWN, grant kept, flag stays set after release.
REQ-038 rst pulsed while proc 3 owns with a memory grant active -> all outputs 0 immediately; after rst low, Req_proc=8'h08 -> grant to proc 3 with rr_ptr restarted from 0.
